// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: a 4-entry TX FIFO, a 1-entry RX holding
// register, a free-running cycle counter and a registered read port.
//
// Handshakes (TX: DataInValid/DataInReady, RX: DataOutValid/DataOutReady):
// a byte moves on a rising edge where valid and ready are both 1. Valid
// never depends on ready, and the payload is stable while valid is high.
module uart_mmio (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic        REUART,
   input  logic        WEUART,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);

   localparam logic [2:0] SEL_TX_STAT = 3'd0;
   localparam logic [2:0] SEL_RX_STAT = 3'd1;
   localparam logic [2:0] SEL_RX_DATA = 3'd2;
   localparam logic [2:0] SEL_TX_DATA = 3'd3;
   localparam logic [2:0] SEL_CYCLES  = 3'd4;

   logic [2:0]  sel;
   logic [7:0]  tx_mem [4];
   logic [1:0]  tx_rd_ptr;
   logic [1:0]  tx_wr_ptr;
   logic [2:0]  tx_count;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_not_full;
   logic [7:0]  rx_byte;
   logic        rx_full;
   logic        rx_capture;
   logic        rx_pop;
   logic [31:0] cycle_cnt;
   logic [31:0] read_mux;

   // Upstream already qualified the window; only the word index matters.
   assign sel          = Address[4:2];
   assign tx_not_full  = (tx_count != 3'd4);
   assign tx_push      = WEUART && (sel == SEL_TX_DATA) && tx_not_full;
   assign DataInValid  = (tx_count != 3'd0);
   assign DataIn       = tx_mem[tx_rd_ptr];
   assign tx_pop       = DataInValid && DataInReady;
   assign DataOutReady = !rx_full;
   assign rx_capture   = DataOutValid && !rx_full;
   // Popping an empty holding register is a harmless re-read of the old byte.
   assign rx_pop       = REUART && (sel == SEL_RX_DATA) && rx_full;

   // Read decode from pre-edge state.
   always_comb begin
      read_mux = 32'd0;
      case (sel)
         SEL_TX_STAT: read_mux = {31'd0, tx_not_full};
         SEL_RX_STAT: read_mux = {31'd0, rx_full};
         SEL_RX_DATA: read_mux = {24'd0, rx_byte};
         SEL_CYCLES:  read_mux = cycle_cnt;
         default:     read_mux = 32'd0;
      endcase
   end

   // TX FIFO storage, pointers and occupancy; a full-FIFO write is dropped.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         tx_rd_ptr <= 2'd0;
         tx_wr_ptr <= 2'd0;
         tx_count  <= 3'd0;
         for (int i = 0; i < 4; i++) tx_mem[i] <= 8'd0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wr_ptr] <= WriteData[7:0];
            tx_wr_ptr         <= tx_wr_ptr + 2'd1;
         end
         if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 2'd1;
         if (tx_push && !tx_pop)      tx_count <= tx_count + 3'd1;
         else if (tx_pop && !tx_push) tx_count <= tx_count - 3'd1;
      end
   end

   // RX holding register; capture needs it empty so it never meets a pop.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rx_byte <= 8'd0;
         rx_full <= 1'b0;
      end else if (rx_capture) begin
         rx_byte <= DataOut;
         rx_full <= 1'b1;
      end else if (rx_pop) begin
         rx_full <= 1'b0;
      end
   end

   // Free-running cycle counter; a write to its address clears it.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)                            cycle_cnt <= 32'd0;
      else if (WEUART && (sel == SEL_CYCLES)) cycle_cnt <= 32'd0;
      else                                   cycle_cnt <= cycle_cnt + 32'd1;
   end

   // Registered load data: updates only on read cycles, holds otherwise.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)      ReadData <= 32'd0;
      else if (REUART) ReadData <= read_mux;
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with TX/RX expected-byte scoreboards.
module tb_uart_mmio;

  localparam logic [31:0] A_TXS = 32'h8000_0000;
  localparam logic [31:0] A_RXS = 32'h8000_0004;
  localparam logic [31:0] A_RXD = 32'h8000_0008;
  localparam logic [31:0] A_TXD = 32'h8000_000C;
  localparam logic [31:0] A_CNT = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = 32'd0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready = 1'b0;
  logic [7:0]  data_out = 8'd0;
  logic        data_out_valid = 1'b0;
  logic        data_out_ready;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_mmio dut (
    .Clock(clk), .Reset(rst_n), .Address(address), .REUART(re), .WEUART(we),
    .WriteData(write_data), .ReadData(read_data), .DataIn(data_in),
    .DataInValid(data_in_valid), .DataInReady(data_in_ready),
    .DataOut(data_out), .DataOutValid(data_out_valid),
    .DataOutReady(data_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    address = addr;
    re = 1'b1;
    tick();
    re = 1'b0;
    chk(tag, read_data, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data);
    address = addr;
    write_data = {24'hABCDE0, data};
    we = 1'b1;
    // FIFO model: the queue holds exactly what the FIFO holds at this point
    if (addr == A_TXD && exp_q.size() < 4) exp_q.push_back(data);
    tick();
    we = 1'b0;
  endtask

  // TX scoreboard: a pop happens on the next rising edge, inputs are stable here
  always @(negedge clk) begin
    if (rst_n && data_in_valid && data_in_ready) begin
      if (exp_q.size() == 0) begin
        chk("tx_extra_byte", {24'd0, data_in}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'd0, data_in}, {24'd0, exp_q.pop_front()});
        tx_seen++;
      end
    end
  end

  initial begin
    // reset state, checked while reset is still held
    #13;
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_tx_valid", {31'd0, data_in_valid}, 32'd0);
    chk("rst_rx_ready", {31'd0, data_out_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // counter is 0 at the first edge after release, then 1
    rd(A_CNT, 32'd0, "cnt_first_edge");
    rd(A_CNT, 32'd1, "cnt_second_edge");

    rd(A_TXS, 32'd1, "tx_status_empty");
    rd(A_RXS, 32'd0, "rx_status_empty");
    chk("idle_tx_valid", {31'd0, data_in_valid}, 32'd0);
    chk("idle_rx_ready", {31'd0, data_out_ready}, 32'd1);

    // fill the FIFO with the transmitter stalled, overflow write is dropped
    wr(A_TXD, 8'h41);
    chk("tx_valid_after_push", {31'd0, data_in_valid}, 32'd1);
    chk("tx_head_first", {24'd0, data_in}, 32'h41);
    wr(A_TXD, 8'h42);
    wr(A_TXD, 8'h43);
    wr(A_TXD, 8'h44);
    wr(A_TXD, 8'h45);
    rd(A_TXS, 32'd0, "tx_status_full");
    chk("tx_head_held", {24'd0, data_in}, 32'h41);

    // drain: four consecutive pops then empty
    data_in_ready = 1'b1;
    repeat (3) tick();
    chk("tx_valid_before_last", {31'd0, data_in_valid}, 32'd1);
    tick();
    chk("tx_valid_drained", {31'd0, data_in_valid}, 32'd0);
    chk("tx_drain_count", tx_seen, 32'd4);

    // push during a pop keeps two entries; 0x55 leaves third
    data_in_ready = 1'b0;
    wr(A_TXD, 8'h51);
    wr(A_TXD, 8'h52);
    data_in_ready = 1'b1;
    wr(A_TXD, 8'h55);
    tick();
    chk("tx_two_left_valid", {31'd0, data_in_valid}, 32'd1);
    chk("tx_two_left_head", {24'd0, data_in}, 32'h55);
    tick();
    chk("tx_pushpop_empty", {31'd0, data_in_valid}, 32'd0);
    chk("tx_total", tx_seen, 32'd7);
    data_in_ready = 1'b0;

    // RX: offered for 3 cycles, only the first byte may be taken
    data_out = 8'h5A;
    data_out_valid = 1'b1;
    rx_q.push_back(8'h5A);
    tick();
    data_out = 8'hA7;
    repeat (2) tick();
    data_out_valid = 1'b0;
    chk("rx_ready_full", {31'd0, data_out_ready}, 32'd0);
    rd(A_RXS, 32'd1, "rx_status_full");
    rd(A_RXD, {24'd0, rx_q.pop_front()}, "rx_data_pop");
    chk("rx_ready_after_pop", {31'd0, data_out_ready}, 32'd1);
    rd(A_RXD, 32'h5A, "rx_data_empty_reread");
    rd(A_RXS, 32'd0, "rx_status_after_reread");

    // counter: clear, then 10 edges elapse before the read edge
    wr(A_CNT, 8'h00);
    repeat (10) tick();
    rd(A_CNT, 32'd10, "cnt_after_clear");
    // read and clear together: read sees the pre-edge value
    address = A_CNT;
    re = 1'b1;
    we = 1'b1;
    tick();
    re = 1'b0;
    we = 1'b0;
    chk("cnt_read_and_clear", read_data, 32'd11);
    rd(A_CNT, 32'd0, "cnt_cleared_same_edge");

    // wrap from all ones
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    rd(A_CNT, 32'hFFFF_FFFF, "cnt_max");
    rd(A_CNT, 32'd0, "cnt_wrap");

    // asynchronous reset mid-stream with TX bytes queued and an RX byte held
    wr(A_TXD, 8'h61);
    wr(A_TXD, 8'h62);
    wr(A_TXD, 8'h63);
    data_out = 8'h33;
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    rd(A_TXS, 32'd1, "tx_status_partial");
    chk("pre_reset_rx_ready", {31'd0, data_out_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", {31'd0, data_in_valid}, 32'd0);
    chk("async_rst_rx_ready", {31'd0, data_out_ready}, 32'd1);
    chk("async_rst_read_data", read_data, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    rd(A_RXD, 32'd0, "rx_byte_cleared");
    chk("tx_empty_after_reset", {31'd0, data_in_valid}, 32'd0);
    chk("tx_queue_drained", exp_q.size(), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
